iqdemap_multi: RTL
==================

Name: iqdemap_multi

Overview:
- Hard-decision IQ demapper for the one-seg receive chain; successor to the fixed BPSK demapper, with BPSK, QPSK and 16QAM selectable at run time.
- Sits after equalisation. Takes one equalised complex symbol (ar, ai) per valid_i.
- Packs the decided bits into WORD_W-bit words for the memory writer, and also emits a serial raw bit stream for the deinterleaver and Viterbi path.
- Adds a partial-word flush and an overflow flag on the raw serialiser.

Parameters:
- IQ_W, 11, width of signed ar/ai samples.
- WORD_W, 128, packed output word width; must be a multiple of 4.
- CNT_W, 8, width of word_bits; must satisfy 2^CNT_W > WORD_W.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset; synchronous, active-high.
- ce  in  1  clock enable; all state advances only when ce=1.
- mode  in  2  constellation select: 0 BPSK, 1 QPSK, 2 16QAM, 3 reserved.
- thr  in  IQ_W-1  16QAM inner/outer magnitude threshold (unsigned).
- flush  in  1  emit the partial word.
- valid_i  in  1  ar/ai valid.
- ar, ai  in  IQ_W signed  I and Q sample.
- valid_o  out  1  one-cycle strobe; writer_data valid.
- writer_data  out  WORD_W  packed bits, first decided bit at the MSB.
- word_bits  out  CNT_W  number of valid bits in writer_data (WORD_W, or fewer after a flush).
- valid_raw  out  1  raw bit valid.
- raw  out  1  serial decided bit.
- ovf  out  1  sticky serialiser overflow.

Behaviour:
- Reset (RST=1 at a CLK edge) clears all outputs and state to 0, including the active mode register. Any partial word or pending raw bits are discarded.
- Accept: a symbol is accepted when ce and valid_i are both 1 and the active mode is not 3. With ce=0, inputs are ignored and all outputs hold, except valid_o and valid_raw, which are forced to 0.
- Mode latching: the active mode register loads from the mode port only on a ce cycle with packer bit count = 0, and takes effect for a symbol accepted in that same cycle. A mode change mid-word is deferred to the next word boundary.
- Active mode 3: symbols are dropped; no packing and no raw output.
- Decisions: s(x) = 1 if x < 0.
  - |x| is computed in IQ_W-1 bits and saturates (-2^(IQ_W-1) maps to 2^(IQ_W-1)-1).
  - m(x) = 1 if |x| < thr.
  - BPSK emits 1 bit: s(ar).
  - QPSK emits 2 bits, in order: s(ar), s(ai).
  - 16QAM emits 4 bits, in order: s(ar), s(ai), m(ar), m(ai).
- Packer:
  - Bits shift in MSB-first; count += n per accepted symbol.
  - When count reaches WORD_W, writer_data and word_bits=WORD_W are registered with valid_o=1 on the next CLK edge (latency 1). Count returns to 0.
  - Words never straddle symbols, because WORD_W is a multiple of 4.
- Flush (ce=1, flush=1, with count after this cycle's accept > 0):
  - Emits the left-aligned, zero-padded partial word with word_bits=count, and clears count.
  - A symbol accepted in the same cycle is included first.
  - If that symbol completes the word, exactly one full word is emitted.
  - Flush with count 0 does nothing.
- Raw serialiser:
  - Holds up to 4 bits with a remaining-bit count rem.
  - Each ce cycle with rem > 0: raw = the oldest bit, valid_raw=1, rem decrements.
  - An accepted symbol loads its bits with rem=n, effective on the next cycle, so the first raw bit appears 1 cycle after accept.
  - If rem >= 2 at the accept edge, the un-emitted bits are lost, the new symbol loads, and ovf is set to 1; ovf clears only on RST.
  - Sustainable input rate: 1 symbol per n ce cycles.

Decomposition:
- Shared package iqdemap_pkg holds:
  - mode constants MODE_BPSK=0, MODE_QPSK=1, MODE_16QAM=2, MODE_RSVD=3;
  - a function bits_per_mode(mode) returning 1/2/4/0;
  - the function abs_sat.
- One natural sub-module, iqdemap_packer (bit shift register, count, flush, word emit). Decision logic and the serialiser stay in the top level.

Test Plan:
- BPSK, 128 symbols alternating ar=-100/+100 with ce=1, continuous valid_i -> one valid_o with writer_data=128'hAAAA...AAAA and word_bits=128; raw stream 1,0,1,0,...; ovf=0.
- QPSK (ar,ai)=(-5,+5) for 64 symbols, valid_i every 2nd ce cycle -> writer_data all bits "10" repeated = 128'hAAAA...; valid_raw continuous with no gaps; ovf=0.
- 16QAM with thr=300; symbols (ar,ai)=(-200,+500) then (+600,-1024) -> raw bits 1,0,1,0 then 0,1,0,0. ai=-1024 saturates to 1023, so it decides outer.
- 16QAM with symbols accepted on consecutive ce cycles -> ovf goes to 1 on the 2nd accept and stays 1 until RST.
- BPSK with 5 symbols (all negative), then flush -> valid_o=1, writer_data=128'hF8000...0, word_bits=5. Mode changed to QPSK mid-word takes effect only after the flush.
- ce toggled 0/1 during a QPSK word -> output identical to the ce=1 run, only stretched. RST asserted mid-word -> outputs 0, partial word discarded, next word packs from bit 127.

Source files
------------

// File: rtl/iqdemap_pkg.sv
// Shared definitions for the multi-constellation hard-decision IQ demapper:
// constellation codes, bits-per-symbol lookup and saturating magnitude.
package iqdemap_pkg;

    localparam logic [1:0] MODE_BPSK  = 2'd0;
    localparam logic [1:0] MODE_QPSK  = 2'd1;
    localparam logic [1:0] MODE_16QAM = 2'd2;
    localparam logic [1:0] MODE_RSVD  = 2'd3;

    // Working width for abs_sat; callers sign-extend into it and truncate back.
    localparam int unsigned ABS_W = 32;

    // Decided bits produced per symbol; the reserved mode produces none.
    function automatic logic [2:0] bits_per_mode(input logic [1:0] mode);
        case (mode)
            MODE_BPSK:  return 3'd1;
            MODE_QPSK:  return 3'd2;
            MODE_16QAM: return 3'd4;
            default:    return 3'd0;
        endcase
    endfunction

    // |x| for a w-bit signed sample, saturated so it fits in w-1 bits:
    // the most negative code maps to the largest positive magnitude.
    function automatic logic [ABS_W-1:0] abs_sat(input logic signed [ABS_W-1:0] x,
                                                 input int unsigned         w);
        logic signed [ABS_W-1:0] lim;
        lim = (ABS_W'(1) <<< (w - 1)) - ABS_W'(1);
        if (x < -lim)
            return $unsigned(lim);
        else if (x < 0)
            return $unsigned(-x);
        else
            return $unsigned(x);
    endfunction

endpackage

// File: rtl/iqdemap_packer.sv
// Packs decided bits MSB-first into WORD_W-bit words, with partial-word flush.
// Ports: CLK/RST (sync, active-high), ce, push (symbol accepted), bits
// (left-aligned decided bits), n_bits (how many are valid), flush;
// valid_o/writer_data/word_bits (registered word output), count (bits held).
module iqdemap_packer #(
    parameter int unsigned WORD_W = 128,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ce,
    input  logic              push,
    input  logic [3:0]        bits,
    input  logic [2:0]        n_bits,
    input  logic              flush,
    output logic              valid_o,
    output logic [WORD_W-1:0] writer_data,
    output logic [CNT_W-1:0]  word_bits,
    output logic [CNT_W-1:0]  count
);

    // Bits are held right-aligned (newest at LSB) and left-aligned on emit.
    logic [WORD_W-1:0] sreg;
    logic [WORD_W-1:0] nxt_sreg;
    logic [CNT_W-1:0]  nxt_cnt;
    logic [CNT_W-1:0]  pad;
    logic              full;

    // State after including this cycle's symbol, if any.
    always_comb begin
        nxt_sreg = sreg;
        nxt_cnt  = count;
        if (push) begin
            nxt_sreg = (sreg << n_bits) | WORD_W'(bits >> (3'd4 - n_bits));
            nxt_cnt  = count + CNT_W'(n_bits);
        end
        full = (nxt_cnt == CNT_W'(WORD_W));
        pad  = CNT_W'(WORD_W) - nxt_cnt;
    end

    // A completed word takes priority, so a flush that lands on a word
    // boundary yields exactly one full word and nothing else.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sreg        <= '0;
            count       <= '0;
            valid_o     <= 1'b0;
            writer_data <= '0;
            word_bits   <= '0;
        end else if (!ce) begin
            valid_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (full) begin
                valid_o     <= 1'b1;
                writer_data <= nxt_sreg;
                word_bits   <= CNT_W'(WORD_W);
                sreg        <= '0;
                count       <= '0;
            end else if (flush && nxt_cnt != '0) begin
                valid_o     <= 1'b1;
                writer_data <= nxt_sreg << pad;
                word_bits   <= nxt_cnt;
                sreg        <= '0;
                count       <= '0;
            end else begin
                sreg  <= nxt_sreg;
                count <= nxt_cnt;
            end
        end
    end

endmodule

// File: rtl/iqdemap_multi.sv
// Hard-decision IQ demapper (BPSK / QPSK / 16QAM) with word packer and a
// serial raw-bit output.
// Ports: CLK/RST (sync, active-high), ce, mode, thr (16QAM inner/outer
// threshold), flush, valid_i/ar/ai (equalised symbol); valid_o/writer_data/
// word_bits (packed words), valid_raw/raw (serial bits), ovf (sticky).
module iqdemap_multi
    import iqdemap_pkg::*;
#(
    parameter int unsigned IQ_W   = 11,
    parameter int unsigned WORD_W = 128,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   ce,
    input  logic [1:0]             mode,
    input  logic [IQ_W-2:0]        thr,
    input  logic                   flush,
    input  logic                   valid_i,
    input  logic signed [IQ_W-1:0] ar,
    input  logic signed [IQ_W-1:0] ai,
    output logic                   valid_o,
    output logic [WORD_W-1:0]      writer_data,
    output logic [CNT_W-1:0]       word_bits,
    output logic                   valid_raw,
    output logic                   raw,
    output logic                   ovf
);

    logic [1:0]      mode_q;
    logic [1:0]      eff_mode;
    logic [CNT_W-1:0] count;
    logic [IQ_W-2:0] mag_r;
    logic [IQ_W-2:0] mag_i;
    logic            s_r;
    logic            s_i;
    logic            m_r;
    logic            m_i;
    logic [3:0]      sym_bits;
    logic [2:0]      n_bits;
    logic            accept;
    logic [3:0]      rbuf;
    logic [2:0]      rem;

    // Mode may only change on a word boundary, and a new mode applies to a
    // symbol arriving in the same cycle it is latched.
    always_comb begin
        eff_mode = (ce && count == '0) ? mode : mode_q;
        n_bits   = bits_per_mode(eff_mode);
        mag_r    = (IQ_W-1)'(abs_sat(ABS_W'(ar), IQ_W));
        mag_i    = (IQ_W-1)'(abs_sat(ABS_W'(ai), IQ_W));
        s_r      = ar[IQ_W-1];
        s_i      = ai[IQ_W-1];
        m_r      = (mag_r < thr);
        m_i      = (mag_i < thr);
        case (eff_mode)
            MODE_BPSK:  sym_bits = {s_r, 3'b000};
            MODE_QPSK:  sym_bits = {s_r, s_i, 2'b00};
            MODE_16QAM: sym_bits = {s_r, s_i, m_r, m_i};
            default:    sym_bits = 4'b0000;
        endcase
        accept = ce && valid_i && (eff_mode != MODE_RSVD);
    end

    // Active mode register.
    always_ff @(posedge CLK) begin
        if (RST)
            mode_q <= MODE_BPSK;
        else if (ce && count == '0)
            mode_q <= mode;
    end

    // Raw serialiser: emits the oldest held bit each ce cycle; a new symbol
    // replaces whatever is left, flagging overflow if 2+ bits were pending.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rbuf      <= '0;
            rem       <= '0;
            valid_raw <= 1'b0;
            raw       <= 1'b0;
            ovf       <= 1'b0;
        end else if (!ce) begin
            valid_raw <= 1'b0;
        end else begin
            valid_raw <= (rem != 3'd0);
            if (rem != 3'd0)
                raw <= rbuf[3];
            if (accept) begin
                rbuf <= sym_bits;
                rem  <= n_bits;
                if (rem >= 3'd2)
                    ovf <= 1'b1;
            end else if (rem != 3'd0) begin
                rbuf <= {rbuf[2:0], 1'b0};
                rem  <= rem - 3'd1;
            end
        end
    end

    iqdemap_packer #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) u_packer (
        .CLK         (CLK),
        .RST         (RST),
        .ce          (ce),
        .push        (accept),
        .bits        (sym_bits),
        .n_bits      (n_bits),
        .flush       (flush),
        .valid_o     (valid_o),
        .writer_data (writer_data),
        .word_bits   (word_bits),
        .count       (count)
    );

endmodule
